awg_cmd_ctrl: RTL and testbench

Multi-channel command decoder and parameter register bank for the AWG.
- Consumes the ASCII byte stream from the UART receiver.
- Per channel, holds the waveform select, frequency, amplitude and phase words that drive the waveform generators.
- Adds channel addressing, decimal numeric entry for all three parameters, and a per-channel frequency sweep driven by an internal tick divider.

---
 rtl/awg_cmd_ctrl_if.sv | 9 +
 rtl/awg_cmd_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_awg_cmd_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/awg_cmd_ctrl_if.sv
// Byte-stream command interface between the UART receiver and awg_cmd_ctrl.
// cmd_valid is a one-cycle strobe qualifying the ASCII byte on cmd.
interface awg_cmd_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd;

  modport master (output cmd_valid, output cmd);
  modport slave  (input  cmd_valid, input  cmd);
endinterface

// File: rtl/awg_cmd_ctrl.sv
// Multi-channel AWG command decoder and parameter register bank.
// Optional macro SWEEP_EN builds the sweep tick divider and per-channel frequency sweep.
module awg_cmd_ctrl #(
  parameter int NCH        = 2,
  parameter int STATE_W    = 5,
  parameter int FREQ_W     = 12,
  parameter int AMP_W      = 8,
  parameter int PHASE_W    = 8,
  parameter int DEF_STATE  = 3,
  parameter int DEF_FREQ   = 1000,
  parameter int DEF_AMP    = 50,
  parameter int DEF_PHASE  = 50,
  parameter int SWEEP_STEP = 100,
  parameter int FREQ_MAX   = 4000,
  parameter int TICK_DIV   = 50000000,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  awg_cmd_ctrl_if.slave              cmd_if,
  output logic [NCH*STATE_W-1:0]     o_state,
  output logic [NCH*FREQ_W-1:0]      o_freq,
  output logic [NCH*AMP_W-1:0]       o_amp,
  output logic [NCH*PHASE_W-1:0]     o_phase,
  output logic [CH_W-1:0]            o_cur_ch,
  output logic                       o_entry_busy,
  output logic                       o_err
);
  localparam int MAXW_FA = (FREQ_W > AMP_W) ? FREQ_W : AMP_W;
  localparam int MAXW    = (MAXW_FA > PHASE_W) ? MAXW_FA : PHASE_W;
  // Four spare bits keep acc*10+9 from overflowing before saturation.
  localparam int ACC_W   = MAXW + 4;
  localparam logic [ACC_W-1:0] FREQ_ALL1  = ACC_W'((2**FREQ_W) - 1);
  localparam logic [ACC_W-1:0] AMP_ALL1   = ACC_W'((2**AMP_W) - 1);
  localparam logic [ACC_W-1:0] PHASE_ALL1 = ACC_W'((2**PHASE_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_CH_SEL, S_NUM} fsm_t;
  typedef enum logic [1:0] {F_FREQ, F_AMP, F_PHASE} field_t;

  fsm_t               r_fsm, w_fsm_next;
  field_t             r_field, w_field_val;
  logic [ACC_W-1:0]   r_acc, w_acc_max, w_acc_prod, w_acc_sat;
  logic [CH_W-1:0]    r_cur_ch;
  logic               r_err;

  logic               w_err, w_set_wave, w_ch_load, w_field_load, w_acc_step, w_commit, w_toggle;
  logic [STATE_W-1:0] w_wave_val;
  logic               w_is_digit;
  logic [3:0]         w_digit;

  assign w_is_digit = (cmd_if.cmd >= 8'h30) && (cmd_if.cmd <= 8'h39);
  assign w_digit    = cmd_if.cmd[3:0];

  always_comb begin
    case (r_field)
      F_AMP:   w_acc_max = AMP_ALL1;
      F_PHASE: w_acc_max = PHASE_ALL1;
      default: w_acc_max = FREQ_ALL1;
    endcase
  end

  assign w_acc_prod = r_acc * ACC_W'(10) + ACC_W'(w_digit);
  assign w_acc_sat  = (w_acc_prod > w_acc_max) ? w_acc_max : w_acc_prod;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_err        = 1'b0;
    w_set_wave   = 1'b0;
    w_wave_val   = '0;
    w_ch_load    = 1'b0;
    w_field_load = 1'b0;
    w_field_val  = r_field;
    w_acc_step   = 1'b0;
    w_commit     = 1'b0;
    w_toggle     = 1'b0;
    if (cmd_if.cmd_valid) begin
      case (r_fsm)
        S_IDLE: begin
          if (w_is_digit && (w_digit <= 4'd4)) begin
            w_set_wave = 1'b1;
            w_wave_val = (w_digit == 4'd0) ? STATE_W'(10) : STATE_W'(w_digit - 4'd1);
          end else begin
            case (cmd_if.cmd)
              "c": w_fsm_next = S_CH_SEL;
              "f": begin w_field_load = 1'b1; w_field_val = F_FREQ;  w_fsm_next = S_NUM; end
              "a": begin w_field_load = 1'b1; w_field_val = F_AMP;   w_fsm_next = S_NUM; end
              "p": begin w_field_load = 1'b1; w_field_val = F_PHASE; w_fsm_next = S_NUM; end
`ifdef SWEEP_EN
              "s": w_toggle = 1'b1;
`endif
              default: w_err = 1'b1;
            endcase
          end
        end
        S_CH_SEL: begin
          w_fsm_next = S_IDLE;
          if (w_is_digit && (32'(w_digit) < NCH)) w_ch_load = 1'b1;
          else                                    w_err     = 1'b1;
        end
        S_NUM: begin
          if (w_is_digit) begin
            w_acc_step = 1'b1;
          end else begin
            w_fsm_next = S_IDLE;
            if (cmd_if.cmd == 8'h0D)      w_commit = 1'b1;
            else if (cmd_if.cmd != 8'h1B) w_err    = 1'b1;
          end
        end
        default: w_fsm_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_ch <= '0;
      r_field  <= F_FREQ;
      r_acc    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_ch_load)    r_cur_ch <= w_digit[CH_W-1:0];
      if (w_field_load) begin
        r_field <= w_field_val;
        r_acc   <= '0;
      end else if (w_acc_step) begin
        r_acc <= w_acc_sat;
      end
    end
  end

`ifdef SWEEP_EN
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + 1'b1;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [STATE_W-1:0] r_state;
      logic [FREQ_W-1:0]  r_freq;
      logic [AMP_W-1:0]   r_amp;
      logic [PHASE_W-1:0] r_phase;
      logic               w_sel;
      assign w_sel = (r_cur_ch == CH_W'(gi));
`ifdef SWEEP_EN
      localparam int FW1 = FREQ_W + 1;
      logic              r_sweep;
      logic [FREQ_W:0]   w_sum;
      logic [FREQ_W-1:0] w_swept;
      assign w_sum   = {1'b0, r_freq} + FW1'(SWEEP_STEP);
      assign w_swept = (w_sum[FREQ_W] || (w_sum > FW1'(FREQ_MAX))) ? FREQ_W'(DEF_FREQ) : w_sum[FREQ_W-1:0];

      always_ff @(posedge i_clk) begin
        if (i_rst)                  r_sweep <= 1'b0;
        else if (w_toggle && w_sel) r_sweep <= ~r_sweep;
      end
`endif

      // A freq commit on a tick cycle takes priority over that channel's sweep step.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_state <= STATE_W'(DEF_STATE);
          r_freq  <= FREQ_W'(DEF_FREQ);
          r_amp   <= AMP_W'(DEF_AMP);
          r_phase <= PHASE_W'(DEF_PHASE);
        end else begin
          if (w_set_wave && w_sel) r_state <= w_wave_val;
          if (w_commit && w_sel && (r_field == F_AMP))   r_amp   <= r_acc[AMP_W-1:0];
          if (w_commit && w_sel && (r_field == F_PHASE)) r_phase <= r_acc[PHASE_W-1:0];
          if (w_commit && w_sel && (r_field == F_FREQ))  r_freq  <= r_acc[FREQ_W-1:0];
`ifdef SWEEP_EN
          else if (w_tick && r_sweep)                    r_freq  <= w_swept;
`endif
        end
      end

      assign o_state[gi*STATE_W +: STATE_W] = r_state;
      assign o_freq[gi*FREQ_W +: FREQ_W]    = r_freq;
      assign o_amp[gi*AMP_W +: AMP_W]       = r_amp;
      assign o_phase[gi*PHASE_W +: PHASE_W] = r_phase;
    end
  endgenerate

  assign o_cur_ch     = r_cur_ch;
  assign o_entry_busy = (r_fsm != S_IDLE);
  assign o_err        = r_err;
endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Directed self-checking bench for awg_cmd_ctrl (2 channels, 10-clock sweep tick).
module tb_awg_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  o_state;
  logic [23:0] o_freq;
  logic [15:0] o_amp;
  logic [15:0] o_phase;
  logic        o_cur_ch;
  logic        o_entry_busy;
  logic        o_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  awg_cmd_ctrl_if u_if();

  awg_cmd_ctrl #(.TICK_DIV(10)) u_dut (
    .i_clk(clk), .i_rst(rst), .cmd_if(u_if.slave),
    .o_state(o_state), .o_freq(o_freq), .o_amp(o_amp), .o_phase(o_phase),
    .o_cur_ch(o_cur_ch), .o_entry_busy(o_entry_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  wire [4:0]  st0 = o_state[4:0];
  wire [4:0]  st1 = o_state[9:5];
  wire [11:0] fr0 = o_freq[11:0];
  wire [11:0] fr1 = o_freq[23:12];
  wire [7:0]  am0 = o_amp[7:0];
  wire [7:0]  am1 = o_amp[15:8];
  wire [7:0]  ph0 = o_phase[7:0];
  wire [7:0]  ph1 = o_phase[15:8];

  // Called at a negedge; the byte is accepted at the next posedge and results are visible on return.
  task automatic send_byte(input logic [7:0] b);
    u_if.cmd_valid = 1'b1;
    u_if.cmd       = b;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    u_if.cmd       = 8'h00;
    $display("[TB] byte 0x%02h busy=%0d err=%0d cur_ch=%0d", b, o_entry_busy, o_err, o_cur_ch);
  endtask

  task automatic test_reset();
    u_if.cmd_valid = 1'b0;
    u_if.cmd       = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++; if ({st1, st0} !== {5'd3, 5'd3}) begin n_fail++; $display("FAIL reset_state: got %0d/%0d expected 3/3", st0, st1); end
    n_tests++; if ({fr1, fr0} !== {12'd1000, 12'd1000}) begin n_fail++; $display("FAIL reset_freq: got %0d/%0d expected 1000/1000", fr0, fr1); end
    n_tests++; if ({am1, am0, ph1, ph0} !== {8'd50, 8'd50, 8'd50, 8'd50}) begin n_fail++; $display("FAIL reset_amp_phase: got amp %0d/%0d phase %0d/%0d expected 50", am0, am1, ph0, ph1); end
    n_tests++; if ({o_cur_ch, o_entry_busy, o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got cur_ch=%0d busy=%0d err=%0d expected 0 0 0", o_cur_ch, o_entry_busy, o_err); end
  endtask

  task automatic test_waveform();
    send_byte("2");
    n_tests++; if (st0 !== 5'd1) begin n_fail++; $display("FAIL wave_ch0: got %0d expected 1", st0); end
    send_byte("c");
    n_tests++; if (o_entry_busy !== 1'b1) begin n_fail++; $display("FAIL chsel_busy: got %0d expected 1", o_entry_busy); end
    send_byte("1");
    n_tests++; if ({o_cur_ch, o_entry_busy} !== 2'b10) begin n_fail++; $display("FAIL chsel_1: got cur_ch=%0d busy=%0d expected 1 0", o_cur_ch, o_entry_busy); end
    send_byte("0");
    n_tests++; if ({st1, st0} !== {5'd10, 5'd1}) begin n_fail++; $display("FAIL wave_ch1_zero: got ch0=%0d ch1=%0d expected 1 10", st0, st1); end
    send_byte("4");
    n_tests++; if (st1 !== 5'd3) begin n_fail++; $display("FAIL wave_ch1_four: got %0d expected 3", st1); end
    send_byte("c");
    send_byte("2");
    n_tests++; if ({o_err, o_cur_ch, o_entry_busy} !== 3'b110) begin n_fail++; $display("FAIL chsel_range: got err=%0d cur_ch=%0d busy=%0d expected 1 1 0", o_err, o_cur_ch, o_entry_busy); end
  endtask

  task automatic test_num_entry();
    send_byte("c"); send_byte("0");
    send_byte("a"); send_byte("1"); send_byte("2"); send_byte("3");
    n_tests++; if ({am0, o_entry_busy} !== {8'd50, 1'b1}) begin n_fail++; $display("FAIL amp_pending: got amp=%0d busy=%0d expected 50 1", am0, o_entry_busy); end
    send_byte(8'h0D);
    n_tests++; if ({am0, am1, o_entry_busy} !== {8'd123, 8'd50, 1'b0}) begin n_fail++; $display("FAIL amp_commit: got ch0=%0d ch1=%0d busy=%0d expected 123 50 0", am0, am1, o_entry_busy); end
    send_byte("p"); send_byte("9"); send_byte("9"); send_byte("9"); send_byte(8'h0D);
    n_tests++; if (ph0 !== 8'd255) begin n_fail++; $display("FAIL phase_sat: got %0d expected 255", ph0); end
    send_byte("a"); send_byte(8'h0D);
    n_tests++; if ({am0, o_err} !== {8'd0, 1'b0}) begin n_fail++; $display("FAIL empty_commit: got amp=%0d err=%0d expected 0 0", am0, o_err); end
    send_byte("f");
    for (int i = 0; i < 6; i++) send_byte("9");
    send_byte(8'h0D);
    n_tests++; if (fr0 !== 12'd4095) begin n_fail++; $display("FAIL freq_sat: got %0d expected 4095", fr0); end
    send_byte("f"); send_byte("1"); send_byte("0"); send_byte("0"); send_byte("0"); send_byte(8'h0D);
    n_tests++; if ({fr0, fr1} !== {12'd1000, 12'd1000}) begin n_fail++; $display("FAIL freq_restore: got %0d/%0d expected 1000/1000", fr0, fr1); end
  endtask

  task automatic test_escape_err();
    send_byte("f"); send_byte("7"); send_byte(8'h1B);
    n_tests++; if ({fr0, o_err, o_entry_busy} !== {12'd1000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL esc: got freq=%0d err=%0d busy=%0d expected 1000 0 0", fr0, o_err, o_entry_busy); end
    send_byte("f"); send_byte("5"); send_byte("z");
    n_tests++; if ({o_err, o_entry_busy} !== 2'b10) begin n_fail++; $display("FAIL num_bad: got err=%0d busy=%0d expected 1 0", o_err, o_entry_busy); end
    @(negedge clk);
    n_tests++; if ({fr0, o_err} !== {12'd1000, 1'b0}) begin n_fail++; $display("FAIL err_pulse: got freq=%0d err=%0d expected 1000 0", fr0, o_err); end
    send_byte("x");
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL idle_bad: got err=%0d expected 1", o_err); end
  endtask

`ifdef SWEEP_EN
  task automatic test_sweep();
    logic [11:0] last_seen = 12'd1000;
    int          exp_freq  = 1000;
    int          changes   = 0;
    int          last_cyc  = 0;
    send_byte("s");
    for (int cyc = 1; cyc <= 400 && changes < 31; cyc++) begin
      @(negedge clk);
      if (fr0 !== last_seen) begin
        exp_freq = (exp_freq + 100 > 4000) ? 1000 : exp_freq + 100;
        n_tests++; if (fr0 !== 12'(exp_freq)) begin n_fail++; $display("FAIL sweep_step%0d: got %0d expected %0d", changes, fr0, exp_freq); end
        if (changes > 0) begin
          n_tests++; if (cyc - last_cyc != 10) begin n_fail++; $display("FAIL sweep_gap%0d: got %0d expected 10", changes, cyc - last_cyc); end
        end
        $display("[TB] sweep cycle %0d freq %0d", cyc, fr0);
        last_seen = fr0;
        last_cyc  = cyc;
        changes++;
      end
    end
    n_tests++; if (changes != 31) begin n_fail++; $display("FAIL sweep_timeout: got %0d steps expected 31", changes); end
    n_tests++; if (fr1 !== 12'd1000) begin n_fail++; $display("FAIL sweep_ch1_idle: got %0d expected 1000", fr1); end
    // Just past a tick: the CR below lands exactly ten clocks later, on the next tick.
    send_byte("f"); send_byte("2"); send_byte("5"); send_byte("0"); send_byte("0");
    repeat (4) @(negedge clk);
    send_byte(8'h0D);
    n_tests++; if (fr0 !== 12'd2500) begin n_fail++; $display("FAIL commit_on_tick: got %0d expected 2500", fr0); end
    repeat (10) @(negedge clk);
    n_tests++; if (fr0 !== 12'd2600) begin n_fail++; $display("FAIL sweep_after_commit: got %0d expected 2600", fr0); end
    send_byte("s");
    repeat (15) @(negedge clk);
    n_tests++; if (fr0 !== 12'd2600) begin n_fail++; $display("FAIL sweep_off: got %0d expected 2600", fr0); end
  endtask
`else
  task automatic test_sweep();
    send_byte("s");
    n_tests++; if ({o_err, fr0} !== {1'b1, 12'd1000}) begin n_fail++; $display("FAIL s_unknown: got err=%0d freq=%0d expected 1 1000", o_err, fr0); end
    repeat (25) @(negedge clk);
    n_tests++; if (fr0 !== 12'd1000) begin n_fail++; $display("FAIL no_sweep: got %0d expected 1000", fr0); end
  endtask
`endif

  task automatic test_reset_mid_entry();
    send_byte("c"); send_byte("1"); send_byte("3");
    send_byte("f"); send_byte("4"); send_byte("2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if ({o_cur_ch, o_entry_busy, st0, st1} !== {1'b0, 1'b0, 5'd3, 5'd3}) begin n_fail++; $display("FAIL rst_mid_ctrl: got cur_ch=%0d busy=%0d st=%0d/%0d expected 0 0 3/3", o_cur_ch, o_entry_busy, st0, st1); end
    n_tests++; if ({fr0, fr1, am0, ph0} !== {12'd1000, 12'd1000, 8'd50, 8'd50}) begin n_fail++; $display("FAIL rst_mid_fields: got freq=%0d/%0d amp=%0d phase=%0d expected 1000/1000 50 50", fr0, fr1, am0, ph0); end
    send_byte(8'h0D);
    n_tests++; if ({o_err, fr0, fr1} !== {1'b1, 12'd1000, 12'd1000}) begin n_fail++; $display("FAIL rst_mid_cr: got err=%0d freq=%0d/%0d expected 1 1000/1000", o_err, fr0, fr1); end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_num_entry();
    test_escape_err();
    test_sweep();
    test_reset_mid_entry();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
